ctu_clsp_ckseq_dl: RTL
======================

CTU_CLSP_CKSEQ_DL -- requirements
Module: ctu_clsp_ckseq_dl

Interface
REQ-001 SHALL have parameter NCH, default 6, number of DRAM clock-enable channels in sequence order ddr0, ddr1, ddr2, ddr3, dram02, dram13.
REQ-002 SHALL have port cmp_gclk  input  1  sole clock, all flops rising-edge.
REQ-003 SHALL have port cmp_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port ckseq_start  input  1  one-cycle request to start DRAM clock sequence.
REQ-005 SHALL have port ckseq_stop  input  1  one-cycle request to stop all DRAM clock enables.
REQ-006 SHALL have port dram_sync_edge  input  1  one-cycle pulse marking a dram_gclk/cmp_gclk coincident edge.
REQ-007 SHALL have port cken_mask  input  NCH  per-channel enable, bit0=ddr0 ... bit5=dram13.
REQ-008 SHALL have port stagger_cnt  input  4  cmp cycles between channel enables, minus one.
REQ-009 SHALL have ports grst_req, dbginit_req  input  1 each  one-cycle reset/debug-init requests.
REQ-010 SHALL have port start_clk_dl  output  1  DRAM clock start level.
REQ-011 SHALL have ports ctu_ddr0..3_dram_cken_dl, ctu_dram02_dram_cken_dl, ctu_dram13_dram_cken_dl  output  1 each  registered clock enables.
REQ-012 SHALL have ports a_grst_dl, a_dbginit_dl  output  1 each  asserted-reset/debug-init levels.
REQ-013 SHALL have ports de_grst_dsync_edge_dl, de_dbginit_dsync_edge_dl  output  1 each  one-cycle deassert-edge pulses.
REQ-014 All outputs SHALL be driven directly from flops (no combinational output paths).

Function
REQ-015 Sequencer FSM states: IDLE, SYNC, STAGGER, RUN, STOP.
REQ-016 IDLE: all cken=0, start_clk_dl=0; ckseq_start -> SYNC and capture cken_mask and stagger_cnt; ckseq_start ignored in any other state.
REQ-017 ckseq_start and ckseq_stop in same IDLE cycle: stop wins, remain IDLE.
REQ-018 SYNC: start_clk_dl=1 from cycle after entry; on dram_sync_edge -> STAGGER, channel index=0, counter=captured stagger_cnt.
REQ-019 STAGGER: counter decrements each cycle; at counter==0 the cken of current index is set (cycle after) if captured mask bit=1, index increments, counter reloads; after index NCH-1 -> RUN.
REQ-020 stagger_cnt=0 SHALL enable one channel per cycle; stagger_cnt=15 one per 16 cycles; masked channels still consume their slot.
REQ-021 RUN: all enabled cken held; changes to cken_mask/stagger_cnt inputs have no effect until next start.
REQ-022 ckseq_stop in SYNC, STAGGER or RUN -> STOP; STOP waits for dram_sync_edge, then clears all cken and start_clk_dl on the following cycle and returns to IDLE.
REQ-023 Reset-edge path: grst_req sets a_grst_dl next cycle; held until next dram_sync_edge, in whose following cycle a_grst_dl=0 and de_grst_dsync_edge_dl=1 for exactly one cycle.
REQ-024 dbginit path identical to REQ-023 using dbginit_req, a_dbginit_dl, de_dbginit_dsync_edge_dl.
REQ-025 grst_req and dbginit_req same cycle: grst serviced, dbginit dropped; any request arriving while either path is pending SHALL be dropped.
REQ-026 grst/dbginit path SHALL run independently of sequencer FSM state.
REQ-027 grst_req coincident with dram_sync_edge: a_grst_dl asserts, deassert waits for the next dram_sync_edge.

Reset
REQ-028 cmp_rst=1 on a clock edge SHALL force FSM=IDLE and every output to 0, clear pending requests, counter and index, regardless of state.
REQ-029 Requests sampled while cmp_rst=1 SHALL be ignored.

Configuration
REQ-030 Macro CTU_CKSEQ_DBGINIT_EN defined: dbginit path per REQ-024/025 present.
REQ-031 Macro CTU_CKSEQ_DBGINIT_EN undefined: dbginit_req ignored, a_dbginit_dl and de_dbginit_dsync_edge_dl constant 0, no dbginit flops.

Verification
REQ-032 mask=6'h3F, stagger_cnt=3, start, sync_edge at cycle 5 -> ddr0 cken at 4 cycles after STAGGER entry, then each next every 4 cycles, dram13 last, RUN reached.
REQ-033 mask=6'h05, stagger_cnt=0 -> only ddr0 and ddr2 go 1, in consecutive-slot cycles 1 and 3 after STAGGER entry; others stay 0.
REQ-034 stop during STAGGER after 2 channels -> no further channels enabled, all cken and start_clk_dl clear cycle after next dram_sync_edge, IDLE.
REQ-035 grst_req and dbginit_req same cycle, sync_edge 7 cycles later -> a_grst_dl high 7 cycles, de_grst pulse 1 cycle, dbginit outputs stay 0.
REQ-036 cmp_rst asserted in RUN with a_grst_dl pending -> all outputs 0 next cycle; subsequent start resequences from ddr0.
REQ-037 Build without CTU_CKSEQ_DBGINIT_EN, pulse dbginit_req -> dbginit outputs remain 0.

Source files
------------

// File: rtl/ctu_clsp_ckseq_dl.sv
// Purpose: DRAM clock-enable start/stop sequencer, plus reset/debug-init deassert-edge alignment.
// Latency: every output is a flop. Enables follow the stagger counter; a_*/de_* update one cycle after a request or sync edge.
// Backpressure: none. Requests are single-cycle pulses, and a request that arrives while that path is busy is dropped.
//
// Ports:
//   cmp_gclk, cmp_rst (synchronous, active-high)
//   ckseq_start / ckseq_stop       - one-cycle sequencer start/stop requests
//   dram_sync_edge                 - one-cycle pulse on a dram_gclk/cmp_gclk coincident edge
//   cken_mask[NCH], stagger_cnt[4] - sampled only when a start is accepted
//   grst_req, dbginit_req          - one-cycle reset/debug-init requests
//   start_clk_dl, ctu_*_dram_cken_dl, a_grst_dl, a_dbginit_dl, de_*_dsync_edge_dl - registered outputs
// Optional feature: the CTU_CKSEQ_DBGINIT_EN macro enables the debug-init path.
// When it is undefined, the dbginit outputs tie to 0 and the path has no flops.

module ctu_clsp_ckseq_dl #(
    parameter int NCH = 6  // channel order: ddr0, ddr1, ddr2, ddr3, dram02, dram13
) (
    input  logic           cmp_gclk,
    input  logic           cmp_rst,
    input  logic           ckseq_start,
    input  logic           ckseq_stop,
    input  logic           dram_sync_edge,
    input  logic [NCH-1:0] cken_mask,
    input  logic [3:0]     stagger_cnt,
    input  logic           grst_req,
    input  logic           dbginit_req,
    output logic           start_clk_dl,
    output logic           ctu_ddr0_dram_cken_dl,
    output logic           ctu_ddr1_dram_cken_dl,
    output logic           ctu_ddr2_dram_cken_dl,
    output logic           ctu_ddr3_dram_cken_dl,
    output logic           ctu_dram02_dram_cken_dl,
    output logic           ctu_dram13_dram_cken_dl,
    output logic           a_grst_dl,
    output logic           a_dbginit_dl,
    output logic           de_grst_dsync_edge_dl,
    output logic           de_dbginit_dsync_edge_dl
);

    localparam int              IDXW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        STAGGER = 3'd2,
        RUN     = 3'd3,
        STOP    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [NCH-1:0]  mask_q;
    logic [NCH-1:0]  cken_q, cken_d;
    logic [3:0]      stag_q;
    logic [3:0]      cnt_q, cnt_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            start_clk_q, start_clk_d;
    logic            start_acc;

    // A stop that arrives in the same cycle as a start cancels the start.
    assign start_acc = (state_q == IDLE) && ckseq_start && !ckseq_stop;

    // ---------------- state register and datapath flops ----------------
    always_ff @(posedge cmp_gclk) begin
        if (cmp_rst) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            stag_q      <= '0;
            cken_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            start_clk_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cken_q      <= cken_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            start_clk_q <= start_clk_d;
            // Mask and stagger are frozen here so that later changes on the inputs do not disturb a running sequence.
            if (start_acc) begin
                mask_q <= cken_mask;
                stag_q <= stagger_cnt;
            end
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_acc) state_d = SYNC;
            SYNC: begin
                if (ckseq_stop)          state_d = STOP;
                else if (dram_sync_edge) state_d = STAGGER;
            end
            STAGGER: begin
                if (ckseq_stop)                              state_d = STOP;
                else if (cnt_q == 4'd0 && idx_q == LAST_IDX) state_d = RUN;
            end
            RUN:     if (ckseq_stop) state_d = STOP;
            STOP:    if (dram_sync_edge) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- output / datapath next values ----------------
    always_comb begin
        cken_d      = cken_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        start_clk_d = start_clk_q;
        case (state_q)
            IDLE: begin
                cken_d      = '0;
                start_clk_d = 1'b0;
                cnt_d       = '0;
                idx_d       = '0;
            end
            SYNC: begin
                start_clk_d = 1'b1;
                if (!ckseq_stop && dram_sync_edge) begin
                    idx_d = '0;
                    cnt_d = stag_q;
                end
            end
            STAGGER: begin
                // A stop freezes the enables where they are; the slot that expires in the same cycle is not granted.
                if (!ckseq_stop) begin
                    if (cnt_q == 4'd0) begin
                        // A masked channel still uses up its slot.
                        if (mask_q[idx_q]) cken_d[idx_q] = 1'b1;
                        idx_d = idx_q + IDXW'(1);
                        cnt_d = stag_q;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            RUN: begin
            end
            STOP: begin
                if (dram_sync_edge) begin
                    cken_d      = '0;
                    start_clk_d = 1'b0;
                end
            end
            default: begin
                cken_d      = '0;
                start_clk_d = 1'b0;
            end
        endcase
    end

    assign start_clk_dl            = start_clk_q;
    assign ctu_ddr0_dram_cken_dl   = cken_q[0];
    assign ctu_ddr1_dram_cken_dl   = cken_q[1];
    assign ctu_ddr2_dram_cken_dl   = cken_q[2];
    assign ctu_ddr3_dram_cken_dl   = cken_q[3];
    assign ctu_dram02_dram_cken_dl = cken_q[4];
    assign ctu_dram13_dram_cken_dl = cken_q[5];

    // ---------------- reset / debug-init deassert alignment ----------------
    // Each a_* level is held until a dram_sync_edge, and the de_* pulse fires on the cycle after that edge.
    // A sync edge in the same cycle as the request does not release it; the release waits for the next sync edge.
    logic a_grst_q, de_grst_q;
    logic path_busy;

`ifdef CTU_CKSEQ_DBGINIT_EN
    logic a_dbg_q, de_dbg_q;

    assign path_busy = a_grst_q | a_dbg_q;

    always_ff @(posedge cmp_gclk) begin
        if (cmp_rst) begin
            a_dbg_q  <= 1'b0;
            de_dbg_q <= 1'b0;
        end else begin
            de_dbg_q <= 1'b0;
            if (a_dbg_q) begin
                if (dram_sync_edge) begin
                    a_dbg_q  <= 1'b0;
                    de_dbg_q <= 1'b1;
                end
            end else if (dbginit_req && !grst_req && !path_busy) begin
                // If grst is requested in the same cycle, grst is serviced and this request is dropped.
                a_dbg_q <= 1'b1;
            end
        end
    end

    assign a_dbginit_dl             = a_dbg_q;
    assign de_dbginit_dsync_edge_dl = de_dbg_q;
`else
    logic unused_dbginit_req;

    assign unused_dbginit_req       = dbginit_req;
    assign path_busy                = a_grst_q;
    assign a_dbginit_dl             = 1'b0;
    assign de_dbginit_dsync_edge_dl = 1'b0;
`endif

    always_ff @(posedge cmp_gclk) begin
        if (cmp_rst) begin
            a_grst_q  <= 1'b0;
            de_grst_q <= 1'b0;
        end else begin
            de_grst_q <= 1'b0;
            if (a_grst_q) begin
                if (dram_sync_edge) begin
                    a_grst_q  <= 1'b0;
                    de_grst_q <= 1'b1;
                end
            end else if (grst_req && !path_busy) begin
                a_grst_q <= 1'b1;
            end
        end
    end

    assign a_grst_dl             = a_grst_q;
    assign de_grst_dsync_edge_dl = de_grst_q;

endmodule
